// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared RV32I datapath.
// Latency: none (plain wires); the controller drives the control side combinationally.
// Backpressure: the memory stalls the controller through mem_ready only.
interface multicycle_controller_if;
  // instruction fields and datapath status
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  // datapath controls
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       illegal_op;
  logic [3:0] state;

  // controller side
  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op, state
  );

  // datapath / memory side
  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/writeback.
// Latency: 3-5 cycles per instruction (2 for an illegal op), plus one per memory wait cycle.
// Backpressure: stalls in FETCH, MEMREAD and MEMWRITE until mem_ready; ignores it elsewhere.
module multicycle_controller (
  input  logic                       clk,
  input  logic                       rst,
  multicycle_controller_if.master    bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;

  // State register; a synchronous reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and per-state controls; anything not driven in a state stays 0.
  always_comb begin
    state_d       = S_FETCH;
    alu_op        = 2'b00;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_write_raw = bus.mem_ready;
        ir_write_raw = bus.mem_ready;
        state_d      = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
        state_d      = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b01;
        pc_write_raw = bus.zero;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU decoder: R-type sub needs op[5] so that addi with Instr[30]=1 stays an add.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state, not just DECODE.
  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Write enables are killed combinationally during reset so an aborted instruction commits nothing.
  assign bus.PCWrite    = pc_write_raw  & ~rst;
  assign bus.IRWrite    = ir_write_raw  & ~rst;
  assign bus.MemWrite   = mem_write_raw & ~rst;
  assign bus.RegWrite   = reg_write_raw & ~rst;
  assign bus.illegal_op = illegal_raw   & ~rst;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [16:0] obs_ctl;
  assign obs_ctl = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                    bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                    bus.ImmSrc, bus.illegal_op};

  // Order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc illegal_op
  function automatic logic [16:0] ctl(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] alu, input logic [1:0] imm,
                                      input logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
  endfunction

  // Push the expected cycle, compare at the falling edge, then step past the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] c);
    exp_t e;
    exp_t got;
    e.tag = tag; e.st = st; e.ctl = c;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    checks++;
    assert (bus.state === got.st) else begin
      failures++;
      $error("FAIL %s state: got %0d expected %0d", got.tag, bus.state, got.st);
    end
    checks++;
    assert (obs_ctl === got.ctl) else begin
      failures++;
      $error("FAIL %s ctl: got %b expected %b", got.tag, obs_ctl, got.ctl);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.op = LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;

    // reset held: FETCH muxes visible, every enable forced low even with mem_ready=1
    cyc("rst1", 4'd0, ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    cyc("rst2", 4'd0, ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    rst = 1'b0;

    // lw, mem_ready high: 0,1,2,3,4
    cyc("lw_f",   4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    cyc("lw_d",   4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    cyc("lw_ma",  4'd2, ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0));
    cyc("lw_mr",  4'd3, ctl(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    cyc("lw_wb",  4'd4, ctl(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,0));

    // sw with two wait cycles in MEMWRITE
    bus.op = SW;
    cyc("sw_f",   4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b01,0));
    cyc("sw_d",   4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0));
    cyc("sw_ma",  4'd2, ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0));
    bus.mem_ready = 1'b0;
    cyc("sw_w0",  4'd5, ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0));
    cyc("sw_w1",  4'd5, ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0));
    bus.mem_ready = 1'b1;
    cyc("sw_w2",  4'd5, ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0));

    // R-type sub
    bus.op = RTY; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    cyc("sub_f",  4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    cyc("sub_d",  4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    cyc("sub_ex", 4'd6, ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0));
    cyc("sub_wb", 4'd7, ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));

    // addi with Instr[30]=1 stays add
    bus.op = ITY;
    cyc("addi_f",  4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    cyc("addi_d",  4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    cyc("addi_ex", 4'd8, ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0));
    cyc("addi_wb", 4'd7, ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));

    // slti -> 101, then R-type or -> 011
    bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
    cyc("slti_f",  4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    cyc("slti_d",  4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    cyc("slti_ex", 4'd8, ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b101,2'b00,0));
    cyc("slti_wb", 4'd7, ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    bus.op = RTY; bus.funct3 = 3'b110;
    cyc("or_f",    4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    cyc("or_d",    4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    cyc("or_ex",   4'd6, ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b011,2'b00,0));
    cyc("or_wb",   4'd7, ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));

    // beq taken, preceded by one fetch wait cycle
    bus.op = BEQ; bus.funct3 = 3'b000; bus.zero = 1'b1; bus.mem_ready = 1'b0;
    cyc("beq_fw",  4'd0, ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b10,0));
    bus.mem_ready = 1'b1;
    cyc("beq_f",   4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b10,0));
    cyc("beq_d",   4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    cyc("beq_t",   4'd10, ctl(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0));

    // beq not taken
    bus.zero = 1'b0;
    cyc("bne_f",   4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b10,0));
    cyc("bne_d",   4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    cyc("bne_nt",  4'd10, ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0));

    // jal: 0,1,9,7
    bus.op = JAL;
    cyc("jal_f",   4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b11,0));
    cyc("jal_d",   4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0));
    cyc("jal_j",   4'd9, ctl(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0));
    cyc("jal_wb",  4'd7, ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b11,0));

    // illegal opcode: one pulse in DECODE, straight back to FETCH
    bus.op = BAD;
    cyc("ill_f",   4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    cyc("ill_d",   4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,1));

    // lw with a read wait, then reset in MEMWB kills RegWrite and returns to FETCH
    bus.op = LW;
    cyc("lw2_f",   4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    cyc("lw2_d",   4'd1, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    cyc("lw2_ma",  4'd2, ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0));
    bus.mem_ready = 1'b0;
    cyc("lw2_mw",  4'd3, ctl(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    bus.mem_ready = 1'b1;
    cyc("lw2_mr",  4'd3, ctl(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    rst = 1'b1;
    cyc("lw2_rst", 4'd4, ctl(0,0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,0));
    rst = 1'b0;
    cyc("post_f",  4'd0, ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
